// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM response path: default base address,
// byte-lane masks and the table of legal write-enable patterns.
package data_sram_resp_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

    localparam logic [3:0] WE_NONE  = 4'b0000;
    localparam logic [3:0] WE_B0    = 4'b0001;
    localparam logic [3:0] WE_B1    = 4'b0010;
    localparam logic [3:0] WE_B2    = 4'b0100;
    localparam logic [3:0] WE_B3    = 4'b1000;
    localparam logic [3:0] WE_H_LO  = 4'b0011;
    localparam logic [3:0] WE_H_HI  = 4'b1100;
    localparam logic [3:0] WE_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE,
        ACC_ERR
    } acc_kind_e;

    // A pattern is legal only if its lowest enabled lane matches the byte offset.
    function automatic logic weLegal(input logic [3:0] we, input logic [1:0] lo);
        logic ok;
        case (we)
            WE_NONE: ok = 1'b1;
            WE_B0:   ok = (lo == 2'd0);
            WE_B1:   ok = (lo == 2'd1);
            WE_B2:   ok = (lo == 2'd2);
            WE_B3:   ok = (lo == 2'd3);
            WE_H_LO: ok = (lo == 2'd0);
            WE_H_HI: ok = (lo == 2'd2);
            WE_WORD: ok = (lo == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_sram_resp_bram.sv
// Word-wide block RAM with per-byte write enables; read-first, one-cycle read.
module bram_bytewe #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: address decode, write-enable legality check, error
// pulse and access counters wrapped around a byte-writable block RAM.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam logic [32:0] SPAN_BYTES = 33'd4 << DEPTH_LOG2;

    logic [31:0]           offset;
    logic                  inRange;
    logic                  legal;
    acc_kind_e             accKind;
    logic                  bramEn;
    logic [31:0]           bramRdata;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  rdZero_q, rdZero_d;
    logic [31:0]           rdCnt_q, rdCnt_d;
    logic [31:0]           wrCnt_q, wrCnt_d;

    // Wraparound subtraction makes addresses below BASE_ADDR land out of range.
    assign offset  = data_sram_addr - BASE_ADDR;
    assign inRange = ({1'b0, offset} < SPAN_BYTES);
    assign legal   = weLegal(data_sram_we, data_sram_addr[1:0]);

    always_comb begin
        accKind = ACC_IDLE;
        if (data_sram_en) begin
            if (!(inRange && legal)) begin
                accKind = ACC_ERR;
            end else if (data_sram_we == WE_NONE) begin
                accKind = ACC_READ;
            end else begin
                accKind = ACC_WRITE;
            end
        end
    end

    assign bramEn = !reset && (accKind == ACC_READ || accKind == ACC_WRITE);

    bram_bytewe #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clk    (clk),
        .en_i   (bramEn),
        .we_i   (data_sram_we),
        .addr_i (offset[DEPTH_LOG2+1:2]),
        .wdata_i(data_sram_wdata),
        .rdata_o(bramRdata)
    );

    // rdZero_q masks the RAM output after reset or a rejected access until
    // the next accepted access reloads it; idle cycles leave everything held.
    always_comb begin
        rvalid_d = (accKind == ACC_READ);
        err_d    = (accKind == ACC_ERR);
        rdZero_d = rdZero_q;
        rdCnt_d  = rdCnt_q;
        wrCnt_d  = wrCnt_q;
        case (accKind)
            ACC_READ: begin
                rdZero_d = 1'b0;
                rdCnt_d  = rdCnt_q + 32'd1;
            end
            ACC_WRITE: begin
                rdZero_d = 1'b0;
                wrCnt_d  = wrCnt_q + 32'd1;
            end
            ACC_ERR:  rdZero_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdZero_q <= 1'b1;
            rdCnt_q  <= 32'd0;
            wrCnt_q  <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdZero_q <= rdZero_d;
            rdCnt_q  <= rdCnt_d;
            wrCnt_q  <= wrCnt_d;
        end
    end

    assign data_sram_rdata  = rdZero_q ? 32'h0 : bramRdata;
    assign data_sram_rvalid = rvalid_q;
    assign data_sram_err    = err_q;
    assign rd_cnt           = rdCnt_q;
    assign wr_cnt           = wrCnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp with hand-computed
// expected values for reads, partial writes, errors, reset and counter wrap.
module tb_data_sram_resp;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        data_sram_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_resp dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_sram_rvalid(data_sram_rvalid),
        .data_sram_err   (data_sram_err),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] wd);
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResp(input string tag, input logic [31:0] rdata,
                             input logic rvalid, input logic err);
        checkOutput({tag, "_rdata"},  data_sram_rdata, rdata);
        checkOutput({tag, "_rvalid"}, {31'd0, data_sram_rvalid}, {31'd0, rvalid});
        checkOutput({tag, "_err"},    {31'd0, data_sram_err}, {31'd0, err});
    endtask

    task automatic checkCnt(input string tag, input logic [31:0] rd, input logic [31:0] wr);
        checkOutput({tag, "_rdcnt"}, rd_cnt, rd);
        checkOutput({tag, "_wrcnt"}, wr_cnt, wr);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, B, 32'h0);
        checkResp("reset", 32'h0, 1'b0, 1'b0);
        checkCnt("reset", 32'd0, 32'd0);
        reset = 1'b0;

        applyStimulus(1'b1, 4'b1111, B + 32'h10, 32'hdead_beef);
        checkResp("wr_word", 32'h0, 1'b0, 1'b0);
        checkCnt("wr_word", 32'd0, 32'd1);
        applyStimulus(1'b1, 4'b0000, B + 32'h10, 32'h0);
        checkResp("rd_word", 32'hdead_beef, 1'b1, 1'b0);
        checkCnt("rd_word", 32'd1, 32'd1);
        applyStimulus(1'b0, 4'b0000, B + 32'h10, 32'h0);
        checkResp("idle_hold", 32'hdead_beef, 1'b0, 1'b0);

        applyStimulus(1'b1, 4'b1100, B + 32'h12, 32'h1234_0000);
        checkResp("wr_half_readfirst", 32'hdead_beef, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, B + 32'h10, 32'h0);
        checkResp("rd_half", 32'h1234_beef, 1'b1, 1'b0);
        checkCnt("rd_half", 32'd2, 32'd2);

        applyStimulus(1'b1, 4'b0001, B + 32'h11, 32'h0000_00ff);
        checkResp("lane_mismatch", 32'h0, 1'b0, 1'b1);
        checkCnt("lane_mismatch", 32'd2, 32'd2);
        applyStimulus(1'b0, 4'b0000, B, 32'h0);
        checkResp("err_one_cycle", 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, B + 32'h10, 32'h0);
        checkResp("rd_unchanged", 32'h1234_beef, 1'b1, 1'b0);

        applyStimulus(1'b1, 4'b0010, B + 32'h11, 32'h0000_5500);
        applyStimulus(1'b1, 4'b0000, B + 32'h10, 32'h0);
        checkResp("rd_byte1", 32'h1234_55ef, 1'b1, 1'b0);
        checkCnt("rd_byte1", 32'd4, 32'd3);

        applyStimulus(1'b1, 4'b0000, B - 32'h4, 32'h0);
        checkResp("below_base", 32'h0, 1'b0, 1'b1);
        checkCnt("below_base", 32'd4, 32'd3);
        applyStimulus(1'b1, 4'b0000, B + 32'h4000, 32'h0);
        checkResp("past_top", 32'h0, 1'b0, 1'b1);

        applyStimulus(1'b1, 4'b1111, B + 32'h3ffc, 32'ha5a5_a5a5);
        checkResp("wr_last", 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, B + 32'h3ffc, 32'h0);
        checkResp("rd_last", 32'ha5a5_a5a5, 1'b1, 1'b0);
        checkCnt("rd_last", 32'd5, 32'd4);

        applyStimulus(1'b1, 4'b0101, B + 32'h10, 32'hffff_ffff);
        checkResp("bad_pattern", 32'h0, 1'b0, 1'b1);
        checkCnt("bad_pattern", 32'd5, 32'd4);

        applyStimulus(1'b1, 4'b1111, B + 32'h20, 32'hcafe_f00d);
        applyStimulus(1'b1, 4'b0000, B + 32'h20, 32'h0);
        checkResp("b2b_rd", 32'hcafe_f00d, 1'b1, 1'b0);
        checkCnt("b2b_rd", 32'd6, 32'd5);
        applyStimulus(1'b1, 4'b0000, B + 32'h10, 32'h0);
        checkResp("pre_reset_rd", 32'h1234_55ef, 1'b1, 1'b0);

        reset = 1'b1;
        applyStimulus(1'b1, 4'b1111, B + 32'h20, 32'h1111_1111);
        checkResp("mid_reset", 32'h0, 1'b0, 1'b0);
        checkCnt("mid_reset", 32'd0, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 4'b0000, B + 32'h20, 32'h0);
        checkResp("after_reset_rd", 32'hcafe_f00d, 1'b1, 1'b0);
        checkCnt("after_reset_rd", 32'd1, 32'd0);

        force dut.wrCnt_q = 32'hffff_ffff;
        #1;
        release dut.wrCnt_q;
        checkOutput("wr_cnt_preload", wr_cnt, 32'hffff_ffff);
        applyStimulus(1'b1, 4'b1111, B + 32'h24, 32'h0bad_f00d);
        checkResp("wrap_wr", 32'h0, 1'b0, 1'b0);
        checkCnt("wrap_wr", 32'd1, 32'd0);
        applyStimulus(1'b0, 4'b0000, B, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
